obi_mem_responder: RTL and testbench

// OBI-style memory responder: the slave end of the core's load/store/fetch bus.

---
 rtl/obi_mem_responder.sv | 130 +++++++++++++
 tb/tb_obi_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: single-outstanding OBI-style memory slave with a word array
// and a fixed wait between grant and a one-cycle response pulse.
`default_nettype none

module obi_mem_responder #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] LAT4     = 4'(LATENCY);
  localparam bit         ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             lat_we;
  logic [IDX_W-1:0] lat_idx;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             commit;
  logic             com_we;
  logic [IDX_W-1:0] com_idx;
  logic [WIDTH-1:0] com_wdata;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr;

  assign req_idx     = addr_i[IDX_W+1:2];
  assign unused_addr = ^{addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0]};
  assign gnt_o       = rst_n && (state == S_IDLE || state == S_RESP);
  assign accept      = req_i && gnt_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // With zero latency the commit uses the live request rather than the latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    com_we    = lat_we;
    com_idx   = lat_idx;
    com_wdata = lat_wdata;
    case (state)
      S_IDLE, S_RESP: begin
        state_nxt = S_IDLE;
        if (accept) begin
          cnt_nxt = LAT4;
          if (ZERO_LAT) begin
            commit    = 1'b1;
            com_we    = we_i;
            com_idx   = req_idx;
            com_wdata = wdata_i;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          commit    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= we_i;
      lat_idx   <= req_idx;
      lat_wdata <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= commit;
      if (commit) begin
        rdata_o <= com_we ? '0 : mem[com_idx];
      end
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && com_we) begin
      mem[com_idx] <= com_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_mem_responder.sv
// Directed self-checking bench for obi_mem_responder (LATENCY=2 and LATENCY=0 instances).
`default_nettype none

module tb_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic        req0, we0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0, rdata0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  obi_mem_responder #(.WIDTH(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata)
  );

  obi_mem_responder #(.WIDTH(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full handshake on the LATENCY=2 instance; returns in the response cycle.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string name);
    int cyc;
    int g;
    g = 0;
    while (!gnt && g < 20) begin step(); g++; end
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    cyc = 1;
    while (!rvalid && cyc < 20) begin step(); cyc++; end
    check({name, " latency"}, cyc, 32'd3);
    check({name, " rdata"}, rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nv;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0007, 32'hA5A5_A5A5, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_1004, 32'h0,        32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0044, 32'h2222_2222, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0040, 32'h0,        32'h1111_1111};
    vecs[7] = '{1'b0, 32'h0000_0047, 32'h0,        32'h2222_2222};

    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) step();
    check("reset gnt", {31'd0, gnt}, 32'd0);
    check("reset rvalid", {31'd0, rvalid}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    req = 1'b0;
    rst_n = 1'b1;
    step();
    check("post-reset gnt", {31'd0, gnt}, 32'd1);

    // Cycle-accurate write with inputs disturbed and req held during WAIT.
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    step();
    we = 1'b0; addr = 32'h14; wdata = 32'h0000_0BAD;
    check("k+1 gnt", {31'd0, gnt}, 32'd0);
    check("k+1 rvalid", {31'd0, rvalid}, 32'd0);
    step();
    check("k+2 gnt", {31'd0, gnt}, 32'd0);
    check("k+2 rvalid", {31'd0, rvalid}, 32'd0);
    step();
    check("k+3 rvalid", {31'd0, rvalid}, 32'd1);
    check("k+3 rdata", rdata, 32'd0);
    check("k+3 gnt", {31'd0, gnt}, 32'd1);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    step();
    check("k+4 rvalid", {31'd0, rvalid}, 32'd0);

    nv = 8;
    for (int i = 0; i < nv; i++) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    end

    xact(1'b1, 32'h20, 32'h1234, 32'h0, "b2b write");
    check("b2b in resp", {31'd0, rvalid}, 32'd1);
    xact(1'b0, 32'h20, 32'h0, 32'h1234, "b2b read");

    // Reset one cycle after accepting a write must abort it cleanly.
    xact(1'b1, 32'h30, 32'h1, 32'h0, "pre-abort write");
    step();
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h0000_FFFF;
    step();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    #1;
    check("abort rvalid", {31'd0, rvalid}, 32'd0);
    check("abort gnt", {31'd0, gnt}, 32'd0);
    step();
    rst_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 4; c++) begin
        step();
        if (rvalid) stray++;
      end
      check("abort stray rvalid", stray, 32'd0);
    end
    xact(1'b0, 32'h30, 32'h0, 32'h1, "post-abort read");

    // Zero-latency instance: response one cycle after every accept.
    check("lat0 idle gnt", {31'd0, gnt0}, 32'd1);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h77;
    step();
    check("lat0 w1 rvalid", {31'd0, rvalid0}, 32'd1);
    check("lat0 w1 rdata", rdata0, 32'd0);
    check("lat0 resp gnt", {31'd0, gnt0}, 32'd1);
    we0 = 1'b0; addr0 = 32'h8; wdata0 = '0;
    step();
    check("lat0 r1 rvalid", {31'd0, rvalid0}, 32'd1);
    check("lat0 r1 rdata", rdata0, 32'h77);
    we0 = 1'b1; addr0 = 32'hC; wdata0 = 32'h99;
    step();
    check("lat0 w2 rvalid", {31'd0, rvalid0}, 32'd1);
    check("lat0 w2 rdata", rdata0, 32'd0);
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    step();
    check("lat0 idle rvalid", {31'd0, rvalid0}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'hC;
    step();
    check("lat0 r2 rvalid", {31'd0, rvalid0}, 32'd1);
    check("lat0 r2 rdata", rdata0, 32'h99);
    req0 = 1'b0; addr0 = '0;
    step();
    check("lat0 end rvalid", {31'd0, rvalid0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
